// File: rtl/brd_status.sv
// ============================================================================
// Module   : brd_status
// Brief    : Board-input status port with synchronizer, per-bit debounce,
//            sticky rising-edge events and a maskable interrupt.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module brd_status #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wen,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic [WIDTH-1:0] status_in,
  output logic             irq
);

  localparam int              c_CW         = (DEBOUNCE_CYCLES <= 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CW-1:0] c_TERM       = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      c_ADDR_STATE = 2'd0;
  localparam logic [1:0]      c_ADDR_EVENT = 2'd1;
  localparam logic [1:0]      c_ADDR_MASK  = 2'd2;
  localparam logic [1:0]      c_ADDR_RAW   = 2'd3;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_event;
  logic [WIDTH-1:0] r_mask;
  logic [c_CW-1:0]  r_cnt [WIDTH];

  logic [WIDTH-1:0] w_stable_nxt;
  logic [c_CW-1:0]  w_cnt_nxt [WIDTH];
  logic             w_wr;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rise;

  // Stable only follows sync2 after DEBOUNCE_CYCLES consecutive mismatches;
  // any single agreeing cycle restarts the count.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic w_mismatch;
    logic w_term;

    assign w_mismatch       = r_sync2[gi] ^ r_stable[gi];
    assign w_term           = (r_cnt[gi] == c_TERM);
    assign w_stable_nxt[gi] = (w_mismatch && w_term) ? r_sync2[gi] : r_stable[gi];
    assign w_cnt_nxt[gi]    = (w_mismatch && !w_term) ? (r_cnt[gi] + c_CW'(1)) : '0;
  end

  assign w_wr   = cs & wen;
  assign w_clr  = (w_wr && (addr == c_ADDR_EVENT)) ? din : '0;
  assign w_rise = w_stable_nxt & ~r_stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_event  <= '0;
      r_mask   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1  <= status_in;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_nxt;
      r_cnt    <= w_cnt_nxt;
      // A rise on the same edge as a clear keeps the event set.
      r_event  <= (r_event & ~w_clr) | w_rise;
      if (w_wr && (addr == c_ADDR_MASK)) begin
        r_mask <= din;
      end
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      c_ADDR_STATE: dout = r_stable;
      c_ADDR_EVENT: dout = r_event;
      c_ADDR_MASK:  dout = r_mask;
      c_ADDR_RAW:   dout = r_sync2;
      default:      dout = '0;
    endcase
  end

  assign irq = |(r_event & r_mask);

endmodule

`default_nettype wire

// File: tb/tb_brd_status.sv
// ============================================================================
// Module   : tb_brd_status
// Brief    : Self-checking bench for brd_status against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_brd_status;

  localparam int W  = 32;
  localparam int DC = 4;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic         cs        = 1'b0;
  logic         wen       = 1'b0;
  logic [1:0]   addr      = 2'd0;
  logic [W-1:0] din       = '0;
  logic [W-1:0] status_in = '0;
  logic [W-1:0] dout;
  logic         irq;

  int checks = 0;
  int errors = 0;

  brd_status #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr),
    .din(din), .dout(dout), .status_in(status_in), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: stable flips once DC consecutive sampled edges disagree.
  logic [W-1:0] m_s1, m_s2, m_stable, m_event, m_mask;
  int           m_run [W];

  always @(posedge clk or posedge reset) begin
    logic [W-1:0] nstable;
    logic [W-1:0] clr;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_event = '0; m_mask = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      nstable = m_stable;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_stable[i]) m_run[i] = 0;
        else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DC) begin
            nstable[i] = m_s2[i];
            m_run[i]   = 0;
          end
        end
      end
      clr     = (cs && wen && addr == 2'd1) ? din : '0;
      m_event = (m_event & ~clr) | (nstable & ~m_stable);
      if (cs && wen && addr == 2'd2) m_mask = din;
      m_stable = nstable;
      m_s2     = m_s1;
      m_s1     = status_in;
    end
  end

  function automatic logic [W-1:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return m_stable;
      2'd1:    return m_event;
      2'd2:    return m_mask;
      default: return m_s2;
    endcase
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
    cs = 1'b1; wen = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; wen = 1'b0; din = '0;
  endtask

  task automatic quiesce();
    status_in = '0;
    repeat (DC + 4) @(negedge clk);
    bus_write(2'd1, '1);
  endtask

  task automatic test_reset();
    reset = 1'b1; status_in = 32'hFFFF_0000;
    repeat (3) @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #1;
      checks++;
      if (dout !== '0) begin
        errors++; $display("FAIL reset_dout a=%0d: got %h expected 0", a, dout);
      end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_latency();
    status_in = 32'h1; addr = 2'd0; reset = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= DC + 2; k++) begin
      @(posedge clk); #1;
      addr = 2'd3; #0.5;
      checks++;
      if (dout[0] !== 1'b1) begin
        errors++; $display("FAIL lat_raw k=%0d: got %b expected 1", k, dout[0]);
      end
      addr = 2'd0; #0.5;
      checks++;
      if (dout !== ((k >= DC + 1) ? 32'h1 : 32'h0)) begin
        errors++; $display("FAIL lat_state k=%0d: got %h expected %h", k, dout, (k >= DC + 1) ? 32'h1 : 32'h0);
      end
    end
    @(negedge clk); addr = 2'd1; #1;
    checks++;
    if (dout !== 32'h1) begin errors++; $display("FAIL lat_event: got %h expected 00000001", dout); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL lat_irq: got %b expected 0", irq); end
  endtask

  task automatic test_glitch();
    logic seen;
    status_in[3] = 1'b1;
    repeat (3) @(negedge clk);
    addr = 2'd3; #1;
    checks++;
    if (dout[3] !== 1'b1) begin errors++; $display("FAIL glitch_raw: got %b expected 1", dout[3]); end
    status_in[3] = 1'b0;
    addr = 2'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      checks++;
      if (dout[3] !== 1'b0) begin errors++; $display("FAIL glitch_short_state k=%0d: got %b expected 0", k, dout[3]); end
    end
    addr = 2'd1; #1;
    checks++;
    if (dout[3] !== 1'b0) begin errors++; $display("FAIL glitch_short_event: got %b expected 0", dout[3]); end
    status_in[3] = 1'b1;
    repeat (4) @(negedge clk);
    status_in[3] = 1'b0;
    seen = 1'b0; addr = 2'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      seen |= dout[3];
      checks++;
      if (dout !== m_stable) begin errors++; $display("FAIL glitch_long_state k=%0d: got %h expected %h", k, dout, m_stable); end
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL glitch_long_seen: got %b expected 1", seen); end
    addr = 2'd1; #1;
    checks++;
    if (dout !== 32'h9) begin errors++; $display("FAIL glitch_long_event: got %h expected 00000009", dout); end
  endtask

  task automatic test_irq();
    quiesce();
    status_in = 32'h5;
    repeat (DC + 4) @(negedge clk);
    addr = 2'd1; #1;
    checks++;
    if (dout !== 32'h5) begin errors++; $display("FAIL irq_event_init: got %h expected 00000005", dout); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_unmasked: got %b expected 0", irq); end
    bus_write(2'd2, 32'h4); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_mask_set: got %b expected 1", irq); end
    bus_write(2'd1, 32'h4); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_event_clr: got %b expected 0", irq); end
    addr = 2'd1; #1;
    checks++;
    if (dout !== 32'h1) begin errors++; $display("FAIL irq_event_after: got %h expected 00000001", dout); end
    bus_write(2'd2, 32'h0); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask_zero: got %b expected 0", irq); end
    bus_write(2'd2, 32'h1); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_mask_bit0: got %b expected 1", irq); end
    bus_write(2'd2, 32'h0); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask_off: got %b expected 0", irq); end
  endtask

  task automatic test_collision();
    quiesce();
    status_in = 32'h1;
    repeat (DC + 1) @(negedge clk);
    addr = 2'd0; #1;
    checks++;
    if (dout[0] !== 1'b0) begin errors++; $display("FAIL coll_pre_state: got %b expected 0", dout[0]); end
    bus_write(2'd1, 32'h1);
    addr = 2'd0; #1;
    checks++;
    if (dout[0] !== 1'b1) begin errors++; $display("FAIL coll_post_state: got %b expected 1", dout[0]); end
    addr = 2'd1; #1;
    checks++;
    if (dout !== 32'h1) begin errors++; $display("FAIL coll_event: got %h expected 00000001", dout); end
  endtask

  task automatic test_readonly();
    logic [W-1:0] st, raw;
    status_in = 32'hA5;
    repeat (DC + 4) @(negedge clk);
    st = m_stable; raw = m_s2;
    bus_write(2'd0, '1);
    bus_write(2'd3, '1);
    addr = 2'd0; #1;
    checks++;
    if (dout !== st || st !== 32'hA5) begin errors++; $display("FAIL ro_state: got %h expected %h", dout, 32'hA5); end
    addr = 2'd3; #1;
    checks++;
    if (dout !== raw || raw !== 32'hA5) begin errors++; $display("FAIL ro_raw: got %h expected %h", dout, 32'hA5); end
    bus_write(2'd2, 32'hF0);
    cs = 1'b0; wen = 1'b1; addr = 2'd2; din = '1;
    @(negedge clk);
    wen = 1'b0; din = '0; #1;
    checks++;
    if (dout !== 32'hF0) begin errors++; $display("FAIL ro_mask_nocs: got %h expected 000000f0", dout); end
    bus_write(2'd2, 32'h0);
  endtask

  task automatic test_random();
    logic [1:0] wa;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int a = 0; a < 4; a++) begin
        addr = 2'(a); #0.5;
        checks++;
        if (dout !== model_reg(2'(a))) begin
          errors++; $display("FAIL rand_reg n=%0d a=%0d: got %h expected %h", n, a, dout, model_reg(2'(a)));
        end
      end
      checks++;
      if (irq !== |(m_event & m_mask)) begin
        errors++; $display("FAIL rand_irq n=%0d: got %b expected %b", n, irq, |(m_event & m_mask));
      end
      if ($urandom_range(3) == 0) status_in = status_in ^ ($urandom & $urandom & $urandom);
      cs = 1'b0; wen = 1'b0; din = '0;
      if ($urandom_range(3) == 0) begin
        wa  = 2'($urandom_range(3));
        cs  = ($urandom_range(4) != 0);
        wen = 1'b1; addr = wa; din = $urandom;
      end
    end
    @(negedge clk);
    cs = 1'b0; wen = 1'b0; din = '0;
  endtask

  task automatic test_async_reset();
    quiesce();
    status_in = 32'hF;
    repeat (DC + 4) @(negedge clk);
    bus_write(2'd2, 32'hF);
    addr = 2'd1; #1;
    checks++;
    if (dout !== 32'hF || irq !== 1'b1) begin
      errors++; $display("FAIL ar_pre: got event %h irq %b expected 0000000f 1", dout, irq);
    end
    @(negedge clk);
    status_in = 32'hFF;
    repeat (2) @(negedge clk);
    #2; reset = 1'b1; #0.5;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ar_irq: got %b expected 0", irq); end
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a); #0.5;
      checks++;
      if (dout !== '0) begin errors++; $display("FAIL ar_dout a=%0d: got %h expected 0", a, dout); end
    end
    @(negedge clk);
    reset = 1'b0; addr = 2'd1;
    for (int k = 1; k <= DC + 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dout !== ((k == DC + 2) ? 32'hFF : 32'h0)) begin
        errors++; $display("FAIL ar_event k=%0d: got %h expected %h", k, dout, (k == DC + 2) ? 32'hFF : 32'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_irq();
    test_collision();
    test_readonly();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
